// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Fetch-PC sequencer for the in-order pipeline. It owns the next fetch
//   address and keeps at most one instruction-memory request outstanding,
//   using a req/gnt handshake followed by an rvalid response. EX and trap
//   redirects are applied here. Responses that were already in flight when a
//   redirect arrived are discarded. Fetched instructions are handed to decode
//   over a valid/ready handshake.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   EX_taken, EX_alt_pc branch/jump redirect pulse and its target
//   trap_valid, trap_vec trap redirect pulse and its target (wins over EX)
//   imem_req, imem_addr request valid and address (address = fetch PC)
//   imem_gnt            memory accepts the request this cycle
//   imem_rvalid, imem_rdata  response valid and instruction
//   F_valid, F_pc, F_instr   fetched instruction towards decode
//   D_ready             decode accepts F_instr this cycle
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              ILEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            EX_taken,
  input  logic [XLEN-1:0] EX_alt_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            F_valid,
  output logic [XLEN-1:0] F_pc,
  output logic [ILEN-1:0] F_instr,
  input  logic            D_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Redirect targets are forced to word alignment.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};
  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'd4};

  logic [1:0]      state_reg;
  logic [XLEN-1:0] pc_reg;      // next address to request
  logic [XLEN-1:0] req_pc_reg;  // address of the request in flight
  logic            kill_reg;    // in-flight response belongs to a stale path

  logic            redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_inc;

  assign redirect  = trap_valid | EX_taken;
  assign target    = (trap_valid ? trap_vec : EX_alt_pc) & ALIGN_MASK;
  assign pc_inc    = pc_reg + PC_STEP;  // wraps modulo 2^XLEN

  assign imem_req  = (state_reg == ST_REQ);
  assign imem_addr = pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      pc_reg     <= RESET_PC;
      req_pc_reg <= RESET_PC;
      kill_reg   <= 1'b0;
      F_valid    <= 1'b0;
      F_pc       <= RESET_PC;
      F_instr    <= {ILEN{1'b0}};
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (redirect) pc_reg <= target;
          state_reg <= ST_REQ;
        end

        ST_REQ: begin
          if (imem_gnt) begin
            if (redirect) begin
              // The granted address is already stale: mark its response.
              pc_reg   <= target;
              kill_reg <= 1'b1;
            end else begin
              req_pc_reg <= pc_reg;
              pc_reg     <= pc_inc;
              kill_reg   <= 1'b0;
            end
            state_reg <= ST_WAIT;
          end else if (redirect) begin
            // Not yet accepted, so the address may simply be swapped.
            pc_reg <= target;
          end
        end

        ST_WAIT: begin
          if (redirect) begin
            pc_reg   <= target;
            kill_reg <= 1'b1;
          end
          if (imem_rvalid) begin
            if (kill_reg || redirect) begin
              // Wrong-path data: drop it and refetch from the new PC.
              kill_reg  <= 1'b0;
              state_reg <= ST_REQ;
            end else begin
              F_instr   <= imem_rdata;
              F_pc      <= req_pc_reg;
              F_valid   <= 1'b1;
              state_reg <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          // A redirect flushes the held instruction even if decode is ready.
          if (redirect) begin
            F_valid   <= 1'b0;
            pc_reg    <= target;
            state_reg <= ST_REQ;
          end else if (D_ready) begin
            F_valid   <= 1'b0;
            state_reg <= ST_REQ;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//   Directed bench for fetch_ctrl. A small memory model answers requests
//   (grant enable and response delay are bench knobs). Stimulus pushes the
//   expected request addresses and decode hand-offs into queues; a monitor
//   pops and compares whenever the DUT grants a request or hands over an
//   instruction.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_taken;
  logic [31:0] EX_alt_pc;
  logic        trap_valid;
  logic [31:0] trap_vec;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        F_valid;
  logic [31:0] F_pc;
  logic [31:0] F_instr;
  logic        D_ready;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];

  // memory model knobs and state
  logic        gnt_en = 1'b0;
  int          rv_delay = 0;
  logic        req_seen = 1'b0;
  logic [31:0] addr_seen = 32'h0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt = 0;

  fetch_ctrl #(.XLEN(32), .RESET_PC(RST_PC), .ILEN(32)) u_dut (
    .clk(clk), .rst(rst),
    .EX_taken(EX_taken), .EX_alt_pc(EX_alt_pc),
    .trap_valid(trap_valid), .trap_vec(trap_vec),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .F_valid(F_valid), .F_pc(F_pc), .F_instr(F_instr),
    .D_ready(D_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  // Memory model: acts on the falling edge so its outputs are stable at the
  // next rising edge. A grant seen last half-cycle becomes a response after
  // rv_delay further cycles.
  always @(negedge clk) begin
    if (req_seen && imem_gnt) begin
      pend      = 1'b1;
      pend_addr = addr_seen;
      pend_cnt  = rv_delay;
    end
    imem_rvalid = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    imem_gnt  = imem_req && gnt_en;
    req_seen  = imem_req;
    addr_seen = imem_addr;
  end

  // Monitor: compares every granted request and every accepted hand-off.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (imem_req && imem_gnt) begin
        if (exp_addr_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL req_addr: unexpected request at %08h", imem_addr);
        end else begin
          chk("req_addr", imem_addr, exp_addr_q.pop_front());
        end
      end
      if (F_valid && D_ready && !(trap_valid || EX_taken)) begin
        if (exp_pc_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL handoff: unexpected F_valid pc %08h", F_pc);
        end else begin
          logic [31:0] e;
          e = exp_pc_q.pop_front();
          chk("F_pc", F_pc, e);
          chk("F_instr", F_instr, instr_of(e));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    exp_addr_q.push_back(a);
    exp_pc_q.push_back(a);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_addr_q.size() != 0 || exp_pc_q.size() != 0) && n < 60) begin
      step();
      n++;
    end
    if (exp_addr_q.size() != 0 || exp_pc_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL %s: timeout, %0d req and %0d handoffs outstanding",
               name, exp_addr_q.size(), exp_pc_q.size());
      exp_addr_q.delete();
      exp_pc_q.delete();
    end
  endtask

  task automatic wait_req_low(input string name);
    int n = 0;
    step();
    while (imem_req && n < 30) begin step(); n++; end
    if (imem_req) begin
      vectors++; miscompares++;
      $display("FAIL %s: imem_req never dropped, got 1 expected 0", name);
    end
  endtask

  task automatic wait_fvalid(input string name);
    int n = 0;
    while (!F_valid && n < 30) begin step(); n++; end
    if (!F_valid) begin
      vectors++; miscompares++;
      $display("FAIL %s: F_valid never rose, got 0 expected 1", name);
    end
  endtask

  initial begin
    rst = 1'b1; EX_taken = 1'b0; EX_alt_pc = 32'h0;
    trap_valid = 1'b0; trap_vec = 32'h0; D_ready = 1'b1;
    gnt_en = 1'b1; rv_delay = 0;
    step(); step();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_fvalid", {31'h0, F_valid}, 32'h0);
    chk("rst_fpc", F_pc, RST_PC);
    chk("rst_finstr", F_instr, 32'h0);

    // sequential fetch with a fast memory, including the 0xFFFFFFFC wrap
    expect_fetch(RST_PC); expect_fetch(32'h0);
    expect_fetch(32'h4);  expect_fetch(32'h8);
    rst = 1'b0;
    step();
    chk("lat_req_rise", {31'h0, imem_req}, 32'h1);
    chk("lat_first_addr", imem_addr, RST_PC);
    step();
    chk("lat_wait_fvalid", {31'h0, F_valid}, 32'h0);
    step();
    chk("lat_fvalid", {31'h0, F_valid}, 32'h1);
    chk("lat_fpc", F_pc, RST_PC);
    drain("seq");
    gnt_en = 1'b0;

    // decode stall keeps the hand-off stable and blocks new requests
    exp_addr_q.push_back(32'hC);
    D_ready = 1'b0; gnt_en = 1'b1;
    wait_fvalid("stall_wait");
    for (int i = 0; i < 5; i++) begin
      chk("stall_fvalid", {31'h0, F_valid}, 32'h1);
      chk("stall_fpc", F_pc, 32'hC);
      chk("stall_finstr", F_instr, instr_of(32'hC));
      chk("stall_noreq", {31'h0, imem_req}, 32'h0);
      step();
    end
    exp_pc_q.push_back(32'hC);
    D_ready = 1'b1;
    drain("stall");
    gnt_en = 1'b0;

    // grant withheld: address stable, then redirect (unaligned target) in REQ
    for (int i = 0; i < 4; i++) begin
      step();
      chk("nognt_req", {31'h0, imem_req}, 32'h1);
      chk("nognt_addr", imem_addr, 32'h10);
    end
    EX_taken = 1'b1; EX_alt_pc = 32'h43;
    step();
    EX_taken = 1'b0;
    chk("req_redir_addr", imem_addr, 32'h40);
    chk("req_redir_req", {31'h0, imem_req}, 32'h1);
    expect_fetch(32'h40);
    gnt_en = 1'b1;
    drain("req_redir");
    gnt_en = 1'b0;

    // EX redirect in WAIT before the response: response must be killed
    exp_addr_q.push_back(32'h44);
    rv_delay = 2; gnt_en = 1'b1;
    wait_req_low("wait_redir_enter");
    EX_taken = 1'b1; EX_alt_pc = 32'h100;
    expect_fetch(32'h100);
    step();
    EX_taken = 1'b0;
    chk("wait_redir_noreq", {31'h0, imem_req}, 32'h0);
    drain("wait_redir");
    gnt_en = 1'b0;

    // EX redirect in the same cycle as the response
    exp_addr_q.push_back(32'h104);
    rv_delay = 0; gnt_en = 1'b1;
    wait_req_low("same_redir_enter");
    EX_taken = 1'b1; EX_alt_pc = 32'h180;
    expect_fetch(32'h180);
    step();
    EX_taken = 1'b0;
    chk("same_redir_addr", imem_addr, 32'h180);
    chk("same_redir_fvalid", {31'h0, F_valid}, 32'h0);
    drain("same_redir");
    gnt_en = 1'b0;

    // trap and EX together in HOLD: trap wins, held instruction flushed
    exp_addr_q.push_back(32'h184);
    D_ready = 1'b0; gnt_en = 1'b1;
    wait_fvalid("trap_wait");
    trap_valid = 1'b1; trap_vec = 32'h203;
    EX_taken = 1'b1; EX_alt_pc = 32'h100;
    D_ready = 1'b1;
    expect_fetch(32'h200);
    step();
    trap_valid = 1'b0; EX_taken = 1'b0;
    chk("trap_fvalid", {31'h0, F_valid}, 32'h0);
    chk("trap_req", {31'h0, imem_req}, 32'h1);
    chk("trap_addr", imem_addr, 32'h200);
    drain("trap");
    gnt_en = 1'b0;

    // reset in WAIT; the stale response lands in IDLE and is ignored
    exp_addr_q.push_back(32'h204);
    rv_delay = 1; gnt_en = 1'b1;
    wait_req_low("rst_wait_enter");
    rst = 1'b1; gnt_en = 1'b0;
    #1;
    chk("rstmid_req", {31'h0, imem_req}, 32'h0);
    chk("rstmid_addr", imem_addr, RST_PC);
    chk("rstmid_fvalid", {31'h0, F_valid}, 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("restart_req", {31'h0, imem_req}, 32'h1);
    chk("restart_addr", imem_addr, RST_PC);
    chk("restart_fvalid", {31'h0, F_valid}, 32'h0);
    expect_fetch(RST_PC);
    rv_delay = 0; gnt_en = 1'b1;
    drain("restart");
    gnt_en = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
